// File: rtl/sram_arb_if.sv
// Requester-side bundle for sram_arb: request handshake plus response.
// master = requester (drives req_*), slave = arbiter (drives rdy/rsp).
interface sram_arb_if #(
  parameter int AW = 15,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic          req_wen;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_vld,
    output req_addr,
    output req_wen,
    output req_wdata,
    output req_wstrb,
    input  req_rdy,
    input  rsp_vld,
    input  rsp_rdata
  );

  modport slave (
    input  req_vld,
    input  req_addr,
    input  req_wen,
    input  req_wdata,
    input  req_wstrb,
    output req_rdy,
    output rsp_vld,
    output rsp_rdata
  );
endinterface

// File: rtl/sram_arb.sv
// Round-robin arbiter/sequencer sharing one single-port SRAM between
// m0 (ifetch) and m1 (load/store); partial stores become read-modify-write.
// Ports: clk, rst (sync, active high); m0/m1 sram_arb_if.slave request
// ports; sram_wen/sram_addr/sram_wdata to the SRAM; sram_rdata registered
// read data returned one cycle after the address.
module sram_arb #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  sram_arb_if.slave     m0,
  sram_arb_if.slave     m1,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);
  localparam int SW = DW / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  // Round-robin pointer: port preferred when both request.
  logic ptr;

  // Grant decode
  logic g0;
  logic g1;
  logic gnt;
  logic gsel;

  // Muxed request of the granted port
  logic [AW-1:0] r_addr;
  logic          r_wen;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_full;
  logic          r_zero;
  logic          r_part;

  // Latched partial store
  logic          l_port;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [SW-1:0] l_wstrb;
  logic [DW-1:0] merged;

  // Response one cycle after the SRAM access
  logic pend;
  logic pport;
  logic prd;

  logic rdy0;
  logic rdy1;
  logic rv0;
  logic rv1;

  always_comb begin
    g0 = m0.req_vld & (~m1.req_vld | ~ptr);
    g1 = m1.req_vld & (~m0.req_vld | ptr);
    gnt = ~rst & (state == IDLE) & (g0 | g1);
    gsel = g1 & ~g0;
  end

  always_comb begin
    if (gsel) begin
      r_addr  = m1.req_addr;
      r_wen   = m1.req_wen;
      r_wdata = m1.req_wdata;
      r_wstrb = m1.req_wstrb;
    end else begin
      r_addr  = m0.req_addr;
      r_wen   = m0.req_wen;
      r_wdata = m0.req_wdata;
      r_wstrb = m0.req_wstrb;
    end
    r_full = &r_wstrb;
    r_zero = ~|r_wstrb;
    r_part = r_wen & ~r_full & ~r_zero;
  end

  // Byte merge of latched store data over the word just read back.
  always_comb begin
    merged = sram_rdata;
    for (int i = 0; i < SW; i++) begin
      if (l_wstrb[i]) begin
        merged[i*8 +: 8] = l_wdata[i*8 +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt & r_part) begin
          state_nx = RMW_WR;
        end
      end
      RMW_WR: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs; everything is forced quiet while rst is high.
  always_comb begin
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          rdy0 = g0;
          rdy1 = g1;
          if (gnt) begin
            sram_addr = r_addr;
            if (r_wen & r_full) begin
              sram_wen   = 1'b1;
              sram_wdata = r_wdata;
            end
          end
        end
        RMW_WR: begin
          sram_wen   = 1'b1;
          sram_addr  = l_addr;
          sram_wdata = merged;
        end
        default: begin
          sram_wen = 1'b0;
        end
      endcase
    end
  end

  // Pointer, partial-store latch and response tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 1'b0;
      pend    <= 1'b0;
      pport   <= 1'b0;
      prd     <= 1'b0;
      l_port  <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_wstrb <= '0;
    end else begin
      pend <= 1'b0;
      prd  <= 1'b0;
      if (gnt) begin
        ptr <= ~gsel;
        if (r_part) begin
          l_port  <= gsel;
          l_addr  <= r_addr;
          l_wdata <= r_wdata;
          l_wstrb <= r_wstrb;
        end else begin
          pend  <= 1'b1;
          pport <= gsel;
          prd   <= ~r_wen;
        end
      end
      if (state == RMW_WR) begin
        pend  <= 1'b1;
        pport <= l_port;
        prd   <= 1'b0;
      end
    end
  end

  // Reset in the response cycle drops the pending response.
  always_comb begin
    rv0 = pend & ~rst & ~pport;
    rv1 = pend & ~rst & pport;
  end

  assign m0.req_rdy   = rdy0;
  assign m1.req_rdy   = rdy1;
  assign m0.rsp_vld   = rv0;
  assign m1.rsp_vld   = rv1;
  assign m0.rsp_rdata = (rv0 & prd) ? sram_rdata : '0;
  assign m1.rsp_rdata = (rv1 & prd) ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb with a registered-read SRAM model.
// Table-driven per-cycle vectors plus hand sequences for reset corners.
module tb_sram_arb;
  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  sram_arb_if #(.AW(AW), .DW(DW)) m0_if ();
  sram_arb_if #(.AW(AW), .DW(DW)) m1_if ();

  sram_arb #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (sram_wen) begin
      mem[sram_addr] <= sram_wdata;
    end
    sram_rdata <= mem[sram_addr];
  end

  typedef struct {
    logic        v0;
    logic        w0;
    logic [14:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic        v1;
    logic        w1;
    logic [14:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
    logic        r0;
    logic        r1;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
    logic        we;
    logic [14:0] sa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(
    input logic v0, input logic w0, input logic [14:0] a0,
    input logic [31:0] d0, input logic [3:0] s0,
    input logic v1, input logic w1, input logic [14:0] a1,
    input logic [31:0] d1, input logic [3:0] s1,
    input logic r0, input logic r1,
    input logic rv0, input logic [31:0] rd0,
    input logic rv1, input logic [31:0] rd1,
    input logic we, input logic [14:0] sa, input logic [31:0] wd);
    vec_t x;
    x.v0 = v0; x.w0 = w0; x.a0 = a0; x.d0 = d0; x.s0 = s0;
    x.v1 = v1; x.w1 = w1; x.a1 = a1; x.d1 = d1; x.s1 = s1;
    x.r0 = r0; x.r1 = r1;
    x.rv0 = rv0; x.rd0 = rd0; x.rv1 = rv1; x.rd1 = rd1;
    x.we = we; x.sa = sa; x.wd = wd;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    m0_if.req_vld   = x.v0;
    m0_if.req_wen   = x.w0;
    m0_if.req_addr  = x.a0;
    m0_if.req_wdata = x.d0;
    m0_if.req_wstrb = x.s0;
    m1_if.req_vld   = x.v1;
    m1_if.req_wen   = x.w1;
    m1_if.req_addr  = x.a1;
    m1_if.req_wdata = x.d1;
    m1_if.req_wstrb = x.s1;
  endtask

  task automatic check_vec(input string tag, input vec_t x);
    chk({tag, ".rdy0"}, 32'(m0_if.req_rdy), 32'(x.r0));
    chk({tag, ".rdy1"}, 32'(m1_if.req_rdy), 32'(x.r1));
    chk({tag, ".rsp0_vld"}, 32'(m0_if.rsp_vld), 32'(x.rv0));
    chk({tag, ".rsp0_rdata"}, m0_if.rsp_rdata, x.rd0);
    chk({tag, ".rsp1_vld"}, 32'(m1_if.rsp_vld), 32'(x.rv1));
    chk({tag, ".rsp1_rdata"}, m1_if.rsp_rdata, x.rd1);
    chk({tag, ".sram_wen"}, 32'(sram_wen), 32'(x.we));
    chk({tag, ".sram_addr"}, 32'(sram_addr), 32'(x.sa));
    chk({tag, ".sram_wdata"}, sram_wdata, x.wd);
  endtask

  // Apply one vector after a rising edge, check at the falling edge.
  task automatic step(input string tag, input vec_t x);
    drive(x);
    @(negedge clk);
    check_vec(tag, x);
    @(posedge clk);
    #1;
  endtask

  vec_t idle;
  vec_t q;

  initial begin
    idle = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0, 0,0,0);
    rst = 1'b1;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    drive(idle);

    // Preload during reset; also prove outputs stay quiet under rst.
    @(posedge clk); #1;
    q = mk(1,0,5,0,4'hF, 1,1,3,32'h1,4'h5, 0,0, 0,0, 0,0, 0,0,0);
    drive(q);
    pre_en = 1'b1; pre_addr = 15'd5; pre_data = 32'hDEADBEEF;
    @(negedge clk);
    check_vec("reset", q);
    @(posedge clk); #1;
    pre_addr = 15'd3; pre_data = 32'hAABBCCDD;
    @(posedge clk); #1;
    pre_addr = 15'd9; pre_data = 32'h00000055;
    @(posedge clk); #1;
    pre_en = 1'b0;
    drive(idle);
    rst = 1'b0;

    tbl[0]  = mk(1,0,5,0,4'hF, 0,0,0,0,0, 1,0, 0,0, 0,0, 0,5,0);
    tbl[1]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 1,32'hDEADBEEF, 0,0, 0,0,0);
    tbl[2]  = mk(0,0,0,0,0, 1,1,7,32'h12345678,4'hF, 0,1, 0,0, 0,0,
                 1,7,32'h12345678);
    tbl[3]  = mk(0,0,0,0,0, 1,0,7,0,4'hF, 0,1, 0,0, 1,0, 0,7,0);
    tbl[4]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,32'h12345678, 0,0,0);
    tbl[5]  = mk(0,0,0,0,0, 1,1,3,32'h11223344,4'h5, 0,1, 0,0, 0,0, 0,3,0);
    tbl[6]  = mk(1,0,5,0,4'hF, 0,0,0,0,0, 0,0, 0,0, 0,0, 1,3,32'hAA22CC44);
    tbl[7]  = mk(1,0,5,0,4'hF, 0,0,0,0,0, 1,0, 0,0, 1,0, 0,5,0);
    tbl[8]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 1,32'hDEADBEEF, 0,0, 0,0,0);
    tbl[9]  = mk(0,0,0,0,0, 1,0,3,0,4'hF, 0,1, 0,0, 0,0, 0,3,0);
    tbl[10] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,32'hAA22CC44, 0,0,0);
    tbl[11] = mk(1,1,9,32'hFFFFFFFF,4'h0, 0,0,0,0,0, 1,0, 0,0, 0,0, 0,9,0);
    tbl[12] = mk(1,0,9,0,4'hF, 0,0,0,0,0, 1,0, 1,0, 0,0, 0,9,0);
    tbl[13] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 1,32'h55, 0,0, 0,0,0);
    tbl[14] = mk(1,0,5,0,4'hF, 1,0,3,0,4'hF, 0,1, 0,0, 0,0, 0,3,0);
    tbl[15] = mk(1,0,5,0,4'hF, 1,0,7,0,4'hF, 1,0, 0,0, 1,32'hAA22CC44,
                 0,5,0);
    tbl[16] = mk(1,0,9,0,4'hF, 1,0,7,0,4'hF, 0,1, 1,32'hDEADBEEF, 0,0,
                 0,7,0);
    tbl[17] = mk(1,0,9,0,4'hF, 0,0,0,0,0, 1,0, 0,0, 1,32'h12345678, 0,9,0);
    tbl[18] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 1,32'h55, 0,0, 0,0,0);

    for (int k = 0; k < 19; k++) begin
      step($sformatf("v%0d", k), tbl[k]);
    end

    // Contention from reset: m0 first, then strict alternation.
    rst = 1'b1;
    q = mk(1,0,5,0,4'hF, 1,0,3,0,4'hF, 0,0, 0,0, 0,0, 0,0,0);
    step("cont_rst", q);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q.r0 = (i % 2 == 0);
      q.r1 = (i % 2 == 1);
      q.sa = (i % 2 == 0) ? 15'd5 : 15'd3;
      q.rv0 = (i > 0) && (i % 2 == 1);
      q.rd0 = q.rv0 ? 32'hDEADBEEF : 32'h0;
      q.rv1 = (i > 0) && (i % 2 == 0);
      q.rd1 = q.rv1 ? 32'hAA22CC44 : 32'h0;
      step($sformatf("cont%0d", i), q);
    end
    rst = 1'b1;
    step("cont_end", idle);
    rst = 1'b0;

    // Reset while in RMW_WR: write abandoned, no response.
    q = mk(0,0,0,0,0, 1,1,9,32'hAABBCCDD,4'h3, 0,1, 0,0, 0,0, 0,9,0);
    step("rmwrst_acc", q);
    rst = 1'b1;
    step("rmwrst_rst", idle);
    rst = 1'b0;
    step("rmwrst_after", idle);
    chk("rmwrst_mem9", mem[9], 32'h55);
    // Pointer back at m0 and requests accepted normally.
    q = mk(1,0,9,0,4'hF, 1,0,5,0,4'hF, 1,0, 0,0, 0,0, 0,9,0);
    step("rmwrst_ptr", q);
    q = mk(0,0,0,0,0, 1,0,5,0,4'hF, 0,1, 1,32'h55, 0,0, 0,5,0);
    step("rmwrst_m1", q);
    q = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,32'hDEADBEEF, 0,0,0);
    step("rmwrst_rsp", q);

    // Reset in the cycle after a read accept suppresses the response.
    q = mk(1,0,5,0,4'hF, 0,0,0,0,0, 1,0, 0,0, 0,0, 0,5,0);
    step("rdrst_acc", q);
    rst = 1'b1;
    step("rdrst_rst", idle);
    rst = 1'b0;
    step("rdrst_after", idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
